// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared state encodings, opcode/funct constants, ALU-op codes
//                and the control-vector type for the multicycle MIPS control.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam int ALUOP_WIDTH = 3;
    localparam int STATE_WIDTH = 4;

    // Every 4-bit encoding is assigned; IDLE must stay at zero.
    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_ALU_WB   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ANDI_EX  = 4'd10,
        S_ORI_EX   = 4'd11,
        S_IMM_WB   = 4'd12,
        S_BRANCH   = 4'd13,
        S_JUMP     = 4'd14,
        S_JR       = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // Encoding consumed by the downstream ALU-control decoder.
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_FUNCT = 3'b010;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND   = 3'b011;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR    = 3'b100;

    typedef struct packed {
        logic                   mem_req;
        logic                   iord;
        logic                   mem_write;
        logic                   ir_write;
        logic                   pc_write;
        logic                   pc_write_cond;
        logic                   branch_ne;
        logic [1:0]             pc_src;
        logic                   alu_src_a;
        logic [1:0]             alu_src_b;
        logic                   alu_imm_zext;
        logic [ALUOP_WIDTH-1:0] alu_op;
        logic                   reg_dst;
        logic                   mem_to_reg;
        logic                   reg_write;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_outdec
//  Description : Combinational state -> datapath control vector decode.
//                Only ir_write/pc_write in FETCH depend on mem_ready, and
//                branch_ne follows the opcode while in BRANCH.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_opcode,
    input  logic        i_mem_ready,
    output ctrl_t       o_ctrl
);

    // Default-to-zero decode so IDLE and any non-listed output stay low.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.alu_src_b = 2'b01;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = 2'b11;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_ANDI_EX: begin
                o_ctrl.alu_src_a    = 1'b1;
                o_ctrl.alu_src_b    = 2'b10;
                o_ctrl.alu_op       = ALUOP_AND;
                o_ctrl.alu_imm_zext = 1'b1;
            end
            S_ORI_EX: begin
                o_ctrl.alu_src_a    = 1'b1;
                o_ctrl.alu_src_b    = 2'b10;
                o_ctrl.alu_op       = ALUOP_OR;
                o_ctrl.alu_imm_zext = 1'b1;
            end
            S_ALU_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_IMM_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_src        = 2'b01;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.branch_ne     = (i_opcode == OP_BNE);
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = 2'b10;
            end
            S_JR: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = 2'b11;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_control
//  Description : Main control FSM of the multicycle MIPS datapath. Holds the
//                state register and next-state logic; output decode lives in
//                mips_ctrl_outdec. illegal_op is registered and pulses in the
//                FETCH cycle that follows a DECODE of an unsupported opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               alu_imm_zext,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    state_t r_state;
    state_t w_next;
    logic   w_illegal;
    logic   r_illegal;
    ctrl_t  w_ctrl;

    // Next-state selection; opcode/funct are only meaningful in DECODE,
    // MEMADR and BRANCH, where the instruction register is stable.
    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = (funct == FUNCT_JR) ? S_JR : S_RTYPE_EX;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    OP_ANDI:      w_next = S_ANDI_EX;
                    OP_ORI:       w_next = S_ORI_EX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: w_next = S_ALU_WB;
            S_ADDI_EX,
            S_ANDI_EX,
            S_ORI_EX:   w_next = S_IMM_WB;
            default:    w_next = S_FETCH;
        endcase
    end

    // State register and illegal-opcode pulse; reset abandons any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal;
        end
    end

    mips_ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign mem_req       = w_ctrl.mem_req;
    assign iord          = w_ctrl.iord;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign branch_ne     = w_ctrl.branch_ne;
    assign pc_src        = w_ctrl.pc_src;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_imm_zext  = w_ctrl.alu_imm_zext;
    assign alu_op        = w_ctrl.alu_op;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign illegal_op    = r_illegal;
    assign dbg_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle_control
//  Description : Directed self-checking bench for mips_multicycle_control.
//                Inputs change and outputs are sampled around the falling
//                clock edge; each step compares the full 24-bit control vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond;
    logic       branch_ne, alu_src_a, alu_imm_zext, reg_dst, mem_to_reg;
    logic       reg_write, illegal_op;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] dbg_state;

    int vectors;
    int miscompares;

    mips_multicycle_control #(.ALUOP_W(3), .STATE_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .iord          (iord),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_imm_zext  (alu_imm_zext),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .illegal_op    (illegal_op),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] outs;
    assign outs = {mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond,
                   branch_ne, pc_src, alu_src_a, alu_src_b, alu_imm_zext,
                   alu_op, reg_dst, mem_to_reg, reg_write, illegal_op, dbg_state};

    // Single-field bit masks in the layout of 'outs'.
    localparam logic [23:0] MR        = 24'h800000;
    localparam logic [23:0] IORD_B    = 24'h400000;
    localparam logic [23:0] MW        = 24'h200000;
    localparam logic [23:0] IRW       = 24'h100000;
    localparam logic [23:0] PCW       = 24'h080000;
    localparam logic [23:0] PCWC      = 24'h040000;
    localparam logic [23:0] BNEB      = 24'h020000;
    localparam logic [23:0] PCS_OUT   = 24'h008000;
    localparam logic [23:0] PCS_JMP   = 24'h010000;
    localparam logic [23:0] PCS_A     = 24'h018000;
    localparam logic [23:0] ASA       = 24'h004000;
    localparam logic [23:0] ASB_4     = 24'h001000;
    localparam logic [23:0] ASB_IMM   = 24'h002000;
    localparam logic [23:0] ASB_SH    = 24'h003000;
    localparam logic [23:0] ZEXT      = 24'h000800;
    localparam logic [23:0] AOP_SUB   = 24'h000100;
    localparam logic [23:0] AOP_FN    = 24'h000200;
    localparam logic [23:0] AOP_AND   = 24'h000300;
    localparam logic [23:0] AOP_OR    = 24'h000400;
    localparam logic [23:0] RDST      = 24'h000080;
    localparam logic [23:0] M2R       = 24'h000040;
    localparam logic [23:0] RW        = 24'h000020;
    localparam logic [23:0] ILL       = 24'h000010;

    // Expected vectors per state, composed from the state/output table.
    localparam logic [23:0] E_IDLE    = 24'h000000;
    localparam logic [23:0] E_FETCH_W = MR | ASB_4 | 24'd1;
    localparam logic [23:0] E_FETCH_R = MR | ASB_4 | IRW | PCW | 24'd1;
    localparam logic [23:0] E_DECODE  = ASB_SH | 24'd2;
    localparam logic [23:0] E_MEMADR  = ASA | ASB_IMM | 24'd3;
    localparam logic [23:0] E_MEMRD   = MR | IORD_B | 24'd4;
    localparam logic [23:0] E_MEMWB   = RW | M2R | 24'd5;
    localparam logic [23:0] E_MEMWR   = MR | MW | IORD_B | 24'd6;
    localparam logic [23:0] E_RTYPE   = ASA | AOP_FN | 24'd7;
    localparam logic [23:0] E_ALUWB   = RW | RDST | 24'd8;
    localparam logic [23:0] E_ADDI    = ASA | ASB_IMM | 24'd9;
    localparam logic [23:0] E_ANDI    = ASA | ASB_IMM | AOP_AND | ZEXT | 24'd10;
    localparam logic [23:0] E_ORI     = ASA | ASB_IMM | AOP_OR | ZEXT | 24'd11;
    localparam logic [23:0] E_IMMWB   = RW | 24'd12;
    localparam logic [23:0] E_BEQ     = ASA | AOP_SUB | PCS_OUT | PCWC | 24'd13;
    localparam logic [23:0] E_BNE     = E_BEQ | BNEB;
    localparam logic [23:0] E_JUMP    = PCW | PCS_JMP | 24'd14;
    localparam logic [23:0] E_JR      = PCW | PCS_A | 24'd15;

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
        @(negedge clk);
        vectors++;
        if (outs !== E_IDLE) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", outs, E_IDLE);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (outs !== E_IDLE) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %h expected %h", outs, E_IDLE);
        end
        @(negedge clk);
        vectors++;
        if (outs !== E_FETCH_W) begin
            miscompares++;
            $display("FAIL reset_to_fetch: got %h expected %h", outs, E_FETCH_W);
        end
    endtask

    task automatic test_add();
        logic [23:0] e [4] = '{E_FETCH_R, E_DECODE, E_RTYPE, E_ALUWB};
        opcode = 6'b000000; funct = 6'b100000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            vectors++;
            if (outs !== e[i]) begin
                miscompares++;
                $display("FAIL add step %0d: got %h expected %h", i, outs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        logic [23:0] e [9] = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_MEMADR,
                               E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
        bit r [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int irw_pulses = 0;
        opcode = 6'b100011; funct = 6'b000000;
        for (int i = 0; i < 9; i++) begin
            mem_ready = r[i];
            #1;
            irw_pulses += int'(ir_write);
            vectors++;
            if (outs !== e[i]) begin
                miscompares++;
                $display("FAIL lw step %0d: got %h expected %h", i, outs, e[i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (irw_pulses !== 1) begin
            miscompares++;
            $display("FAIL lw_ir_write_count: got %0d expected 1", irw_pulses);
        end
    endtask

    task automatic test_sw();
        logic [23:0] e [5] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR};
        bit r [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 6'b101011; funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = r[i];
            #1;
            vectors++;
            if (outs !== e[i]) begin
                miscompares++;
                $display("FAIL sw step %0d: got %h expected %h", i, outs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops [2] = '{6'b000101, 6'b000100};
        logic [23:0] eb  [2] = '{E_BNE, E_BEQ};
        for (int k = 0; k < 2; k++) begin
            logic [23:0] e [3];
            e = '{E_FETCH_R, E_DECODE, eb[k]};
            opcode = ops[k]; funct = 6'b000000;
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1;
                #1;
                vectors++;
                if (outs !== e[i]) begin
                    miscompares++;
                    $display("FAIL branch op=%b step %0d: got %h expected %h", ops[k], i, outs, e[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_imm();
        logic [5:0]  ops [3] = '{6'b001101, 6'b001100, 6'b001000};
        logic [23:0] ex  [3] = '{E_ORI, E_ANDI, E_ADDI};
        for (int k = 0; k < 3; k++) begin
            logic [23:0] e [4];
            e = '{E_FETCH_R, E_DECODE, ex[k], E_IMMWB};
            opcode = ops[k]; funct = 6'b100101;
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1;
                #1;
                vectors++;
                if (outs !== e[i]) begin
                    miscompares++;
                    $display("FAIL imm op=%b step %0d: got %h expected %h", ops[k], i, outs, e[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jumps();
        logic [5:0]  ops [2] = '{6'b000000, 6'b000010};
        logic [23:0] ex  [2] = '{E_JR, E_JUMP};
        for (int k = 0; k < 2; k++) begin
            logic [23:0] e [3];
            e = '{E_FETCH_R, E_DECODE, ex[k]};
            opcode = ops[k]; funct = 6'b001000;
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1;
                #1;
                vectors++;
                if (outs !== e[i]) begin
                    miscompares++;
                    $display("FAIL jump op=%b step %0d: got %h expected %h", ops[k], i, outs, e[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_illegal();
        logic [23:0] e [4] = '{E_FETCH_R, E_DECODE, E_FETCH_W | ILL, E_FETCH_W};
        bit r [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        opcode = 6'b111111; funct = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = r[i];
            #1;
            vectors++;
            if (outs !== e[i]) begin
                miscompares++;
                $display("FAIL illegal step %0d: got %h expected %h", i, outs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_memrd();
        logic [23:0] e [4] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD};
        opcode = 6'b100011; funct = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            #1;
            vectors++;
            if (outs !== e[i]) begin
                miscompares++;
                $display("FAIL rst_memrd step %0d: got %h expected %h", i, outs, e[i]);
            end
            if (i < 3) @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== E_IDLE) begin
            miscompares++;
            $display("FAIL rst_async_clear: got %h expected %h", outs, E_IDLE);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== E_IDLE) begin
            miscompares++;
            $display("FAIL rst_held_idle: got %h expected %h", outs, E_IDLE);
        end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (outs !== E_IDLE) begin
            miscompares++;
            $display("FAIL rst_release_idle: got %h expected %h", outs, E_IDLE);
        end
        @(negedge clk);
        vectors++;
        if (outs !== E_FETCH_W) begin
            miscompares++;
            $display("FAIL rst_then_fetch: got %h expected %h", outs, E_FETCH_W);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add();
        test_lw_wait();
        test_sw();
        test_branch();
        test_imm();
        test_jumps();
        test_illegal();
        test_reset_mid_memrd();
        test_add();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. Sits upstream of the ALU-control decoder and drives its 3-bit `alu_op` input, plus every datapath mux select and write enable.
- Decodes `opcode` (and `funct`, for `jr` only) from the instruction register.
- Sequences fetch, decode, execute, memory and writeback steps.
- Stalls on a memory req/ready handshake.

Parameters:
- `ALUOP_W`, 3, width of `alu_op`; fixed encoding shared with the ALU-control decoder.
- `STATE_W`, 4, width of the state register exposed on `dbg_state`.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  instr[31:26] from the instruction register
- `funct`  in  6  instr[5:0]; used only to detect `jr` (`funct` = 001000)
- `mem_ready`  in  1  memory has completed the current access this cycle
- `mem_req`  out  1  memory access request; held until `mem_ready`
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  store enable; valid while `mem_req` is high
- `ir_write`  out  1  instruction register load
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  conditional PC load, gated in the datapath by zero/!zero
- `branch_ne`  out  1  1 = `bne` polarity for `pc_write_cond`
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A (`jr`)
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sext imm << 2
- `alu_imm_zext`  out  1  zero-extend the immediate (`andi`/`ori`)
- `alu_op`  out  3  000 add, 001 sub, 010 use `funct`, 011 and, 100 or
- `reg_dst`  out  1  1 = rd, 0 = rt
- `mem_to_reg`  out  1  1 = MDR, 0 = ALUOut
- `reg_write`  out  1  register file write enable
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- `dbg_state`  out  4  current state encoding

Behaviour:
- **Reset.** `rst_n` low asynchronously forces state IDLE. In IDLE every output is 0, including `alu_op`=000 and `dbg_state`=0. This holds mid-operation too: a pending memory request is abandoned and no write enable may glitch high.
- **Leaving reset.** IDLE → FETCH unconditionally on the first clock edge after `rst_n` rises.
- **Output decode.** Moore outputs decoded from state only, except `ir_write` and `pc_write` in FETCH, which are qualified by `mem_ready`.
- **States and outputs** (unlisted outputs are 0):
  - FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_src`=00. `ir_write` = `pc_write` = `mem_ready`. Stay while `!mem_ready`; on `mem_ready` go to DECODE.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000 (branch target to ALUOut). Next state by opcode:
    - 100011 or 101011 → MEMADR
    - 000000 with `funct`=001000 → JR
    - 000000 otherwise → RTYPE_EX
    - 000100 or 000101 → BRANCH
    - 001000 → ADDI_EX
    - 001100 → ANDI_EX
    - 001101 → ORI_EX
    - 000010 → JUMP
    - anything else → FETCH with `illegal_op`=1 for that single cycle
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Load → MEMRD; store → MEMWR.
  - MEMRD: `mem_req`=1, `iord`=1. Hold until `mem_ready`, then → MEMWB.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
  - MEMWR: `mem_req`=1, `mem_write`=1, `iord`=1. Hold until `mem_ready`, then → FETCH.
  - RTYPE_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010 → ALU_WB.
  - ADDI_EX / ANDI_EX / ORI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op` 000 / 011 / 100 respectively. `alu_imm_zext`=1 for andi/ori. All → IMM_WB.
  - ALU_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
  - IMM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_src`=01, `pc_write_cond`=1, `branch_ne` = (`opcode`==000101) → FETCH.
  - JUMP: `pc_write`=1, `pc_src`=10 → FETCH.
  - JR: `pc_write`=1, `pc_src`=11 → FETCH.
- **Latencies** (counted from FETCH entry, zero wait states): R-type/imm 4 cycles, lw 5, sw 4, beq/bne/j/jr 3. Each `mem_ready` wait cycle adds one.
- **Illegal states.** Any unused state encoding → FETCH on the next clock.
- **Inputs outside DECODE.** `opcode` and `funct` are sampled only in DECODE and in MEMADR/BRANCH; the IR is stable there by construction.
- **Stray ready.** `mem_ready` outside a `mem_req` state is ignored.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - state enum/localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J) and FUNCT_JR
  - ALUOP_ADD/SUB/FUNCT/AND/OR, shared with the ALU-control decoder
- Sub-module `mips_ctrl_outdec`: purely combinational state → output-vector decode, instantiated once. The FSM register and next-state logic stay in the top.

Test Plan:
- Reset mid-MEMRD (`rst_n` low while `mem_req`=1) → all outputs 0 immediately; IDLE then FETCH one clock after release.
- `add` (`opcode` 000000, `funct` 100000), `mem_ready`=1 → states FETCH, DECODE, RTYPE_EX, ALU_WB; `alu_op`=010 in RTYPE_EX; `reg_write`=1 only in ALU_WB.
- `lw` with `mem_ready` low 2 cycles in both FETCH and MEMRD → 9 cycles total; `ir_write` pulses once; `reg_write`=1, `mem_to_reg`=1 in MEMWB.
- `bne` → BRANCH with `alu_op`=001, `pc_src`=01, `pc_write_cond`=1, `branch_ne`=1; `beq` → `branch_ne`=0.
- `ori` → `alu_op`=100, `alu_imm_zext`=1, then IMM_WB with `reg_dst`=0; `jr` (`funct` 001000) → JR with `pc_src`=11, `pc_write`=1.
- Opcode 111111 → `illegal_op` high for exactly one cycle, next state FETCH, no write enables asserted.
